aip_conv_slave: RTL and testbench
=================================

Name: aip_conv_slave

Overview:
- AIP responder for the convolution IP: decodes host accesses on the AIP bus (conf_dbus/write/read/start) and owns the host-visible state.
- Host-visible state: X and Y input buffers, Z output buffer, their address pointers, the configuration register, and the status/interrupt register.
- Presents a simple core-side port to the convolution datapath: start pulse, done pulse, X/Y read ports, Z write port, config value.
- Sits between the top-level AIP pins and the convolution engine.

Parameters:
- DATAWIDTH, 32, AIP data bus width.
- SIZE_XY, 32, depth of X and Y buffers (5-bit pointers).
- SIZE_Z, 64, depth of Z buffer (6-bit pointers).
- IP_ID_VAL, 32'h1000500C, value returned on IP_ID reads.

Ports:
- clk  in  1  system clock, rising edge.
- rst_a  in  1  asynchronous active-low reset.
- en_s  in  1  synchronous enable; when 0, write/read/start are ignored.
- data_in  in  DATAWIDTH  host write data.
- data_out  out  DATAWIDTH  host read data.
- write  in  1  host write strobe.
- read  in  1  host read strobe.
- start  in  1  host start strobe.
- conf_dbus  in  5  access selector.
- int_req  out  1  interrupt request, active-low.
- core_start  out  1  one-cycle start pulse to the engine.
- core_done  in  1  one-cycle completion pulse from the engine.
- conf_reg  out  11  configuration: [9:0] data, [10] shape.
- x_addr  in  5  engine X read address.
- x_rdata  out  DATAWIDTH  X read data, registered, 1-cycle latency.
- y_addr  in  5  engine Y read address.
- y_rdata  out  DATAWIDTH  Y read data, registered, 1-cycle latency.
- z_we  in  1  engine Z write enable.
- z_addr  in  6  engine Z write address.
- z_wdata  in  DATAWIDTH  engine Z write data.

Behaviour:
- Selector codes:
  - 0 = X data, 1 = X pointer, 2 = Y data, 3 = Y pointer, 4 = Z data, 5 = Z pointer.
  - 6 = CONF data, 7 = CONF pointer (accepted, value ignored).
  - 30 = STATUS, 31 = IP_ID.
  - Any other code: writes ignored, reads return 0.
- Reset (rst_a=0, asynchronous):
  - data_out=0, int_req=1, core_start=0, x_rdata=0, y_rdata=0, conf_reg=0.
  - All pointers = 0, status = 0 (busy=0, done flag=0, mask=0).
  - Buffer contents are not reset.
  - Reset asserted mid-run drops busy immediately; a later core_done is still honoured.
- Writes take effect on the rising edge where write=1 and en_s=1:
  - X data (code 0): X[ptr_x] <= data_in, then ptr_x+1 mod 32. Same for Y (code 2). Ignored while busy; pointer unchanged.
  - Pointer codes 1/3/5: pointer <= data_in low bits (5/5/6 bits).
  - Code 4: host writes to Z are ignored.
  - Code 6: conf_reg <= data_in[10:0].
  - Code 30:
    - mask <= data_in[23:16].
    - For each bit i of data_in[7:0] set, flag[i] <= 0 (write-one-to-clear).
- Reads:
  - data_out is combinational from conf_dbus and registered state:
    - codes 0/2/4: buffer[ptr].
    - codes 1/3/5: pointer, zero-extended.
    - code 6: conf_reg, zero-extended.
    - code 30: {8'd0, mask, 7'd0, busy, flags[7:0]}.
    - code 31: IP_ID_VAL.
  - On a rising edge with read=1 and en_s=1 and code 0/2/4, the matching pointer post-increments (wrap 31->0 for X/Y, 63->0 for Z).
- Start:
  - start=1 && en_s=1 at an edge while busy=0 → busy <= 1; core_start=1 for exactly the next cycle.
  - Start while busy is ignored (no pulse).
- Done:
  - core_done=1 → busy <= 0, flag[0] <= 1.
  - Same-edge flag[0] clear and core_done: set wins.
- Engine ports:
  - Z: z_we=1 writes Z[z_addr] <= z_wdata at the edge. A host read of the same Z address in that cycle returns the old value.
  - X/Y reads: x_rdata <= X[x_addr], y_rdata <= Y[y_addr] every cycle.
- Interrupt: flags[7:1] are reserved and read 0. int_req = ~|(flags & mask), registered (one cycle after the flag/mask change).

Test Plan:
- ID/status after reset: read code 31 → IP_ID_VAL; read code 30 → 0; int_req=1.
- Buffer load:
  - Write ptr_x=0, then 32 X words 0..31 → engine x_addr=5 gives x_rdata=5 one cycle later; ptr_x reads 0 (wrapped).
  - 33rd write overwrites X[0].
- Run with interrupt:
  - Write status mask=0x01, conf=0x545, start → core_start high exactly one cycle; status bit8=1.
  - core_done → status=0x00010001; int_req=0 one cycle later.
  - Write 0x00010001 to status → flag cleared, int_req=1.
- Z readback:
  - Engine writes Z[i]=i*3 for i=0..63; host sets ptr_z=0 and reads 64 words → values 0,3,...,189 in order; ptr_z back to 0.
- Busy protection:
  - Second start while busy → no core_start.
  - X write while busy → X unchanged, ptr_x unchanged.
- Boundary cases:
  - Clear-and-done on the same edge → flag[0]=1.
  - en_s=0 with write to code 6 → conf_reg unchanged.
  - rst_a low mid-run → busy=0, int_req=1 asynchronously.

Source files
------------

// File: rtl/aip_conv_slave.sv
// AIP responder for the convolution IP: host-visible buffers, pointers, config and status/interrupt.
// Host reads are combinational; engine X/Y reads have a 1-cycle latency. There is no backpressure.
module aip_conv_slave #(
  parameter int          DATAWIDTH = 32,
  parameter int          SIZE_XY   = 32,
  parameter int          SIZE_Z    = 64,
  parameter logic [31:0] IP_ID_VAL = 32'h1000500C
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req,
  output logic                 core_start,
  input  logic                 core_done,
  output logic [10:0]          conf_reg,
  input  logic [4:0]           x_addr,
  output logic [DATAWIDTH-1:0] x_rdata,
  input  logic [4:0]           y_addr,
  output logic [DATAWIDTH-1:0] y_rdata,
  input  logic                 z_we,
  input  logic [5:0]           z_addr,
  input  logic [DATAWIDTH-1:0] z_wdata
);

  localparam logic [4:0] SEL_X      = 5'd0;
  localparam logic [4:0] SEL_X_PTR  = 5'd1;
  localparam logic [4:0] SEL_Y      = 5'd2;
  localparam logic [4:0] SEL_Y_PTR  = 5'd3;
  localparam logic [4:0] SEL_Z      = 5'd4;
  localparam logic [4:0] SEL_Z_PTR  = 5'd5;
  localparam logic [4:0] SEL_CONF   = 5'd6;
  localparam logic [4:0] SEL_STATUS = 5'd30;
  localparam logic [4:0] SEL_ID     = 5'd31;

  logic [DATAWIDTH-1:0] x_mem [SIZE_XY];
  logic [DATAWIDTH-1:0] y_mem [SIZE_XY];
  logic [DATAWIDTH-1:0] z_mem [SIZE_Z];

  logic [4:0] ptr_x, ptr_y;
  logic [5:0] ptr_z;
  logic       busy, flag0;
  logic [7:0] mask;
  logic       host_wr, host_rd;
  logic [DATAWIDTH-1:0] rd_mux;

  assign host_wr = write & en_s;
  assign host_rd = read & en_s;

  always_comb begin
    rd_mux = '0;
    case (conf_dbus)
      SEL_X:      rd_mux = x_mem[ptr_x];
      SEL_X_PTR:  rd_mux = DATAWIDTH'(ptr_x);
      SEL_Y:      rd_mux = y_mem[ptr_y];
      SEL_Y_PTR:  rd_mux = DATAWIDTH'(ptr_y);
      SEL_Z:      rd_mux = z_mem[ptr_z];
      SEL_Z_PTR:  rd_mux = DATAWIDTH'(ptr_z);
      SEL_CONF:   rd_mux = DATAWIDTH'(conf_reg);
      SEL_STATUS: rd_mux = DATAWIDTH'({8'd0, mask, 7'd0, busy, 7'd0, flag0});
      SEL_ID:     rd_mux = DATAWIDTH'(IP_ID_VAL);
      default:    rd_mux = '0;
    endcase
  end

  // Output is forced to zero while reset is held, independent of buffer contents.
  assign data_out = rst_a ? rd_mux : '0;

  always_ff @(posedge clk) begin
    if (host_wr && conf_dbus == SEL_X && !busy) x_mem[ptr_x] <= data_in;
    if (host_wr && conf_dbus == SEL_Y && !busy) y_mem[ptr_y] <= data_in;
    if (z_we) z_mem[z_addr] <= z_wdata;
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      x_rdata <= '0;
      y_rdata <= '0;
    end else begin
      x_rdata <= x_mem[x_addr];
      y_rdata <= y_mem[y_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      ptr_x      <= '0;
      ptr_y      <= '0;
      ptr_z      <= '0;
      conf_reg   <= '0;
      busy       <= 1'b0;
      flag0      <= 1'b0;
      mask       <= '0;
      int_req    <= 1'b1;
      core_start <= 1'b0;
    end else begin
      if (host_wr && conf_dbus == SEL_X && !busy) ptr_x <= ptr_x + 5'd1;
      else if (host_wr && conf_dbus == SEL_X_PTR) ptr_x <= data_in[4:0];
      else if (host_rd && conf_dbus == SEL_X)     ptr_x <= ptr_x + 5'd1;

      if (host_wr && conf_dbus == SEL_Y && !busy) ptr_y <= ptr_y + 5'd1;
      else if (host_wr && conf_dbus == SEL_Y_PTR) ptr_y <= data_in[4:0];
      else if (host_rd && conf_dbus == SEL_Y)     ptr_y <= ptr_y + 5'd1;

      if (host_wr && conf_dbus == SEL_Z_PTR) ptr_z <= data_in[5:0];
      else if (host_rd && conf_dbus == SEL_Z) ptr_z <= ptr_z + 6'd1;

      if (host_wr && conf_dbus == SEL_CONF) conf_reg <= data_in[10:0];

      if (host_wr && conf_dbus == SEL_STATUS) begin
        mask <= data_in[23:16];
        if (data_in[0]) flag0 <= 1'b0;
      end

      core_start <= 1'b0;
      if (start && en_s && !busy) begin
        busy       <= 1'b1;
        core_start <= 1'b1;
      end

      // Completion is placed last so it beats a same-edge W1C clear.
      if (core_done) begin
        busy  <= 1'b0;
        flag0 <= 1'b1;
      end

      int_req <= ~(flag0 & mask[0]);
    end
  end

endmodule

// File: tb/tb_aip_conv_slave.sv
// Directed bench for aip_conv_slave with a queue of expected values popped at each observation.
module tb_aip_conv_slave;
  logic        clk = 1'b0;
  logic        rst_a, en_s, write, read, start, core_done, z_we;
  logic [31:0] data_in, z_wdata;
  logic [31:0] data_out, x_rdata, y_rdata;
  logic [4:0]  conf_dbus, x_addr, y_addr;
  logic [5:0]  z_addr;
  logic        int_req, core_start;
  logic [10:0] conf_reg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  aip_conv_slave dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
    .write(write), .read(read), .start(start), .conf_dbus(conf_dbus), .int_req(int_req),
    .core_start(core_start), .core_done(core_done), .conf_reg(conf_reg),
    .x_addr(x_addr), .x_rdata(x_rdata), .y_addr(y_addr), .y_rdata(y_rdata),
    .z_we(z_we), .z_addr(z_addr), .z_wdata(z_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e, input logic [31:0] obs);
    exp_q.push_back(e);
    chk(tag, obs);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] code, input logic [31:0] d);
    conf_dbus = code; data_in = d; write = 1'b1;
    cyc();
    write = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [4:0] code, input logic [31:0] e);
    conf_dbus = code;
    #1;
    expect_val(tag, e, data_out);
  endtask

  task automatic rd(input string tag, input logic [4:0] code, input logic [31:0] e);
    peek(tag, code, e);
    read = 1'b1;
    cyc();
    read = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    core_done = 1'b0; z_we = 1'b0; data_in = '0; z_wdata = '0;
    conf_dbus = 5'd31; x_addr = '0; y_addr = '0; z_addr = '0;
    #12;
    expect_val("rst_data_out", 32'h0, data_out);
    expect_val("rst_int_req", 32'h1, 32'(int_req));
    expect_val("rst_core_start", 32'h0, 32'(core_start));
    expect_val("rst_conf_reg", 32'h0, 32'(conf_reg));
    expect_val("rst_x_rdata", 32'h0, x_rdata);
    cyc();
    rst_a = 1'b1;
    cyc();

    rd("ip_id", 5'd31, 32'h1000500C);
    peek("status_after_reset", 5'd30, 32'h0);
    expect_val("int_req_idle", 32'h1, 32'(int_req));

    // Buffer load with wrap and overwrite
    wr(5'd1, 32'd0);
    for (int i = 0; i < 32; i++) wr(5'd0, 32'(i));
    x_addr = 5'd5;
    cyc();
    expect_val("x_rdata_5", 32'd5, x_rdata);
    peek("ptr_x_wrapped", 5'd1, 32'd0);
    wr(5'd0, 32'd100);
    x_addr = 5'd0;
    cyc();
    expect_val("x_overwrite_0", 32'd100, x_rdata);
    peek("ptr_x_after_33", 5'd1, 32'd1);
    wr(5'd1, 32'd7);
    rd("x_host_read_7", 5'd0, 32'd7);
    peek("ptr_x_post_inc", 5'd1, 32'd8);
    wr(5'd3, 32'd0);
    wr(5'd2, 32'd77);
    y_addr = 5'd0;
    cyc();
    expect_val("y_rdata_0", 32'd77, y_rdata);

    // Run with interrupt
    wr(5'd30, 32'h0001_0000);
    wr(5'd6, 32'h545);
    expect_val("conf_reg", 32'h545, 32'(conf_reg));
    peek("conf_read", 5'd6, 32'h545);
    pulse_start();
    expect_val("core_start_pulse", 32'h1, 32'(core_start));
    peek("status_busy", 5'd30, 32'h0001_0100);
    cyc();
    expect_val("core_start_low", 32'h0, 32'(core_start));
    pulse_start();
    expect_val("no_start_busy", 32'h0, 32'(core_start));
    wr(5'd1, 32'd2);
    wr(5'd0, 32'd999);
    peek("ptr_x_busy", 5'd1, 32'd2);
    x_addr = 5'd2;
    cyc();
    expect_val("x_unchanged_busy", 32'd2, x_rdata);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    peek("status_done", 5'd30, 32'h0001_0001);
    expect_val("int_req_lag", 32'h1, 32'(int_req));
    cyc();
    expect_val("int_req_asserted", 32'h0, 32'(int_req));
    wr(5'd30, 32'h0001_0001);
    peek("status_cleared", 5'd30, 32'h0001_0000);
    cyc();
    expect_val("int_req_released", 32'h1, 32'(int_req));

    // Z readback
    for (int i = 0; i < 64; i++) begin
      z_we = 1'b1; z_addr = 6'(i); z_wdata = 32'(i * 3);
      cyc();
    end
    z_we = 1'b0;
    wr(5'd5, 32'd0);
    for (int i = 0; i < 64; i++) rd($sformatf("z_read_%0d", i), 5'd4, 32'(i * 3));
    peek("ptr_z_wrapped", 5'd5, 32'd0);
    wr(5'd5, 32'd10);
    z_we = 1'b1; z_addr = 6'd10; z_wdata = 32'd555;
    peek("z_old_same_cycle", 5'd4, 32'd30);
    cyc();
    z_we = 1'b0;
    peek("z_new_value", 5'd4, 32'd555);
    wr(5'd4, 32'd1234);
    peek("z_host_write_ignored", 5'd4, 32'd555);

    // Clear and done on the same edge: set wins
    pulse_start();
    cyc();
    conf_dbus = 5'd30; data_in = 32'h0001_0001; write = 1'b1; core_done = 1'b1;
    cyc();
    write = 1'b0; core_done = 1'b0;
    peek("clear_vs_done", 5'd30, 32'h0001_0001);

    en_s = 1'b0;
    wr(5'd6, 32'h123);
    en_s = 1'b1;
    expect_val("conf_en_s_low", 32'h545, 32'(conf_reg));

    // Asynchronous reset mid-run
    pulse_start();
    cyc();
    expect_val("int_req_before_rst", 32'h0, 32'(int_req));
    #2;
    rst_a = 1'b0;
    #1;
    expect_val("int_req_async_rst", 32'h1, 32'(int_req));
    expect_val("conf_async_rst", 32'h0, 32'(conf_reg));
    cyc();
    rst_a = 1'b1;
    peek("status_after_rst", 5'd30, 32'h0);
    core_done = 1'b1;
    cyc();
    core_done = 1'b0;
    peek("done_after_rst", 5'd30, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
